nfc_acg_arbiter: RTL
====================

Name: nfc_acg_arbiter

Overview:
- Shares the single atomic-command-generator (ACG) interface between NumOfCmdModules command executors (reset, erase block, program page, read page, ...).
- Each executor drives a full ACG request bundle and pulses its start when it accepts an opcode.
- The arbiter grants the ACG to exactly one executor from start to last step.
- It blocks the upstream command channel while a command is in flight, and flags protocol violations.

Parameters:
NumOfCmdModules, 4, number of executor ports (index 0..N-1); N below.
NumberOfWays, 4, way-select width per executor bundle; W below.

Ports:
iSystemClock  in  1  system clock
iReset  in  1  asynchronous, active-high reset
iCMDValid  in  1  upstream command valid (observed only; not forwarded)
oCMDReady  out  1  upstream ready: arbiter idle AND all iCmdReady bits high
iCmdReady  in  N  per-executor oCMDReady
iCmdStart  in  N  per-executor oStart pulse
iCmdLastStep  in  N  per-executor oLastStep
iCmdACG_Command  in  8N  per-executor ACG command, slice k = [8k+7:8k]
iCmdACG_CommandOption  in  3N  per-executor command option
iCmdACG_TargetWay  in  W*N  per-executor target way
iCmdACG_NumOfData  in  16N  per-executor data count
iCmdACG_CASelect  in  N  per-executor CA select
iCmdACG_CAData  in  40N  per-executor CA data
oCmdACG_Ready  out  8N  ACG ready routed back to each executor
oCmdACG_LastStep  out  8N  ACG last step routed back to each executor
oACG_Command  out  8  to ACG
oACG_CommandOption  out  3  to ACG
oACG_TargetWay  out  W  to ACG
oACG_NumOfData  out  16  to ACG
oACG_CASelect  out  1  to ACG
oACG_CAData  out  40  to ACG
iACG_Ready  in  8  from ACG
iACG_LastStep  in  8  from ACG
oOwner  out  log2(N) (min 1)  current grant index
oBusy  out  1  state != IDLE
oError  out  1  sticky protocol-violation flag

Behaviour:
- State register, one-hot: RESET, IDLE, GRANTED, RELEASE. Owner index and round-robin pointer are registered.
- Reset (async): state=RESET, owner=0, pointer=0, oError=0.
  - All oACG_* idle values: Command=0, CommandOption=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0.
  - oCmdACG_Ready=0, oCmdACG_LastStep=0, oCMDReady=0, oBusy=1.
- RESET -> IDLE unconditionally next cycle.
- IDLE, no start bit set: stay in IDLE. oCMDReady = &iCmdReady.
- IDLE, any iCmdStart set: go to GRANTED next cycle.
  - Owner = first set bit searching upward from pointer, wrapping modulo N.
  - Pointer = owner+1 mod N.
- GRANTED:
  - oACG_* = owner's bundle, combinational mux on the registered owner.
  - oCmdACG_Ready[owner] = iACG_Ready; oCmdACG_LastStep[owner] = iACG_LastStep; all other slices 0.
  - oCMDReady=0.
  - iCmdLastStep[owner]=1 -> RELEASE.
- RELEASE: one-cycle gap with ACG outputs at idle values and all returned ready/last-step slices 0, then -> IDLE.
- Latency:
  - Start at cycle t gives the grant from cycle t+1, i.e. the executor's CMDIssue cycle.
  - Last step at cycle t: bus idle at t+1, oCMDReady may rise at t+2.
- Start seen while GRANTED or RELEASE (upstream violated oCMDReady), or more than one start bit in the same IDLE cycle:
  - oError is set and stays set until reset.
  - Extra starts are ignored; a multi-start in IDLE still grants the round-robin winner.
- iCmdLastStep from a non-owner is ignored and sets oError.
- Reset mid-GRANTED returns everything to the reset values; executors are reset by the same iReset.

Test Plan:
- Reset -> idle bus values; oCMDReady=0 in cycle 1, then 1 once iCmdReady=4'hF.
- iCmdStart=4'b0100 with executor 2 driving Command=8'h08, CAData=40'h60_00_00_00_00 -> from the next cycle oACG_Command=8'h08, oACG_CAData=40'h60_00_00_00_00, oOwner=2; iACG_Ready=8'hFF appears only on slice 2 of oCmdACG_Ready.
- Executor 2 pulses iCmdLastStep -> 1 idle cycle (oACG_Command=0, CASelect=1), then IDLE with oCMDReady=1 and pointer=3.
- Pointer=3 and iCmdStart=4'b0011 -> owner=0 and oError=1; a later start with pointer=1 and only bit 1 set -> owner=1.
- iCmdStart[1] pulsed while owner=0 is GRANTED -> grant unchanged, oError=1, ACG outputs still carry bundle 0.
- Assert iReset while GRANTED with executor 3 owning -> outputs return to reset values immediately; oError=0.

Source files
------------

// File: rtl/nfc_acg_arbiter_if.sv
// nfc_acg_arbiter_if: executor-side request bundles, ACG-side bus and arbiter status.
// The arbiter takes the slave modport; the environment around it drives the master modport.
interface nfc_acg_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    logic              iCMDValid;
    logic              oCMDReady;
    logic [N-1:0]      iCmdReady;
    logic [N-1:0]      iCmdStart;
    logic [N-1:0]      iCmdLastStep;
    logic [8*N-1:0]    iCmdACG_Command;
    logic [3*N-1:0]    iCmdACG_CommandOption;
    logic [W*N-1:0]    iCmdACG_TargetWay;
    logic [16*N-1:0]   iCmdACG_NumOfData;
    logic [N-1:0]      iCmdACG_CASelect;
    logic [40*N-1:0]   iCmdACG_CAData;
    logic [8*N-1:0]    oCmdACG_Ready;
    logic [8*N-1:0]    oCmdACG_LastStep;
    logic [7:0]        oACG_Command;
    logic [2:0]        oACG_CommandOption;
    logic [W-1:0]      oACG_TargetWay;
    logic [15:0]       oACG_NumOfData;
    logic              oACG_CASelect;
    logic [39:0]       oACG_CAData;
    logic [7:0]        iACG_Ready;
    logic [7:0]        iACG_LastStep;
    logic [OW-1:0]     oOwner;
    logic              oBusy;
    logic              oError;
    modport slave (
        input  iCMDValid, iCmdReady, iCmdStart, iCmdLastStep, iCmdACG_Command,
               iCmdACG_CommandOption, iCmdACG_TargetWay, iCmdACG_NumOfData,
               iCmdACG_CASelect, iCmdACG_CAData, iACG_Ready, iACG_LastStep,
        output oCMDReady, oCmdACG_Ready, oCmdACG_LastStep, oACG_Command,
               oACG_CommandOption, oACG_TargetWay, oACG_NumOfData, oACG_CASelect,
               oACG_CAData, oOwner, oBusy, oError
    );
    modport master (
        output iCMDValid, iCmdReady, iCmdStart, iCmdLastStep, iCmdACG_Command,
               iCmdACG_CommandOption, iCmdACG_TargetWay, iCmdACG_NumOfData,
               iCmdACG_CASelect, iCmdACG_CAData, iACG_Ready, iACG_LastStep,
        input  oCMDReady, oCmdACG_Ready, oCmdACG_LastStep, oACG_Command,
               oACG_CommandOption, oACG_TargetWay, oACG_NumOfData, oACG_CASelect,
               oACG_CAData, oOwner, oBusy, oError
    );
endinterface

// File: rtl/nfc_acg_arbiter.sv
// nfc_acg_arbiter: round-robin grant of the single ACG to one command executor from start to last step.
// Flags starts outside IDLE, multi-starts and foreign last steps in a sticky error bit.
module nfc_acg_arbiter #(
    parameter int NumOfCmdModules = 4,
    parameter int NumberOfWays    = 4
) (
    input logic iSystemClock,
    input logic iReset,
    nfc_acg_arbiter_if.slave bus
);
    localparam int N  = NumOfCmdModules;
    localparam int W  = NumberOfWays;
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [3:0] {
        RESET   = 4'b0001,
        IDLE    = 4'b0010,
        GRANTED = 4'b0100,
        RELEASE = 4'b1000
    } state_t;
    state_t state, nextState;
    logic [OW-1:0] owner, pointer, winner, nextOwner, nextPointer;
    logic error, nextError, granted, multiStart, cmdValidUnused;
    logic [N-1:0] ownerMask;
    assign cmdValidUnused = bus.iCMDValid;
    assign granted = state == GRANTED;
    assign multiStart = |(bus.iCmdStart & (bus.iCmdStart - 1'b1));
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state   <= RESET;
            owner   <= '0;
            pointer <= '0;
            error   <= 1'b0;
        end else begin
            state   <= nextState;
            owner   <= nextOwner;
            pointer <= nextPointer;
            error   <= nextError;
        end
    end
    // Scan downward so the set bit nearest the pointer is the last one written.
    always_comb begin
        winner = pointer;
        for (int i = N - 1; i >= 0; i--)
            if (bus.iCmdStart[(int'(pointer) + i) % N]) winner = OW'((int'(pointer) + i) % N);
        ownerMask = '0;
        ownerMask[owner] = 1'b1;
    end
    always_comb begin
        nextState   = state;
        nextOwner   = owner;
        nextPointer = pointer;
        nextError   = error;
        unique case (state)
            RESET: nextState = IDLE;
            IDLE: if (|bus.iCmdStart) begin
                nextState   = GRANTED;
                nextOwner   = winner;
                nextPointer = (int'(winner) == N - 1) ? '0 : winner + OW'(1);
                nextError   = error | multiStart;
            end
            GRANTED: begin
                nextError = error | (|bus.iCmdStart) | (|(bus.iCmdLastStep & ~ownerMask));
                nextState = |(bus.iCmdLastStep & ownerMask) ? RELEASE : GRANTED;
            end
            RELEASE: begin
                nextError = error | (|bus.iCmdStart);
                nextState = IDLE;
            end
            default: nextState = RESET;
        endcase
    end
    assign bus.oACG_Command       = granted ? bus.iCmdACG_Command[8*owner +: 8] : '0;
    assign bus.oACG_CommandOption = granted ? bus.iCmdACG_CommandOption[3*owner +: 3] : '0;
    assign bus.oACG_TargetWay     = granted ? bus.iCmdACG_TargetWay[W*owner +: W] : '0;
    assign bus.oACG_NumOfData     = granted ? bus.iCmdACG_NumOfData[16*owner +: 16] : '0;
    assign bus.oACG_CASelect      = granted ? bus.iCmdACG_CASelect[owner] : 1'b1;
    assign bus.oACG_CAData        = granted ? bus.iCmdACG_CAData[40*owner +: 40] : '0;
    assign bus.oCmdACG_Ready      = granted ? {{(8*(N-1)){1'b0}}, bus.iACG_Ready} << (8*owner) : '0;
    assign bus.oCmdACG_LastStep   = granted ? {{(8*(N-1)){1'b0}}, bus.iACG_LastStep} << (8*owner) : '0;
    assign bus.oCMDReady          = (state == IDLE) & (&bus.iCmdReady);
    assign bus.oBusy              = state != IDLE;
    assign bus.oOwner             = owner;
    assign bus.oError             = error;
endmodule
